// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address logic for a microcoded control unit.
// Holds the registered micro-PC, stretches multi-cycle microinstructions
// through a WAIT state, counts instruction fetches and traps into a sticky
// HALT whenever the next micro-PC would land on TRAP_ADDR.
module micro_sequencer #(
  parameter logic [4:0] FETCH_ADDR = 5'b00000,
  parameter logic [4:0] TRAP_ADDR  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr_ctl,
  input  logic [4:0]  dt1_addr,
  input  logic [4:0]  dt2_addr,
  input  logic        hold,
  input  logic [3:0]  wait_len,
  output logic [4:0]  upc,
  output logic        instr_start,
  output logic        illegal,
  output logic [15:0] instr_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [1:0] AC_SEQ   = 2'b00;
  localparam logic [1:0] AC_DISP1 = 2'b01;
  localparam logic [1:0] AC_DISP2 = 2'b10;
  localparam logic [1:0] AC_FETCH = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [4:0]  upc_q, upc_d;
  logic        illegal_q, illegal_d;
  logic        start_q, start_d;
  logic [15:0] count_q, count_d;

  logic [4:0]  nxt_addr;
  logic        take_nxt;

  // Candidate next micro-PC selected by the current microinstruction.
  always_comb begin
    nxt_addr = upc_q + 5'd1;
    case (addr_ctl)
      AC_SEQ:   nxt_addr = upc_q + 5'd1;
      AC_DISP1: nxt_addr = dt1_addr;
      AC_DISP2: nxt_addr = dt2_addr;
      AC_FETCH: nxt_addr = FETCH_ADDR;
      default:  nxt_addr = upc_q + 5'd1;
    endcase
  end

  // Sequencer FSM: RUN advances or enters WAIT, WAIT counts down, HALT is sticky.
  // A WAIT that reaches wcnt=1 applies the next address on that same edge, so a
  // microinstruction lasts exactly 1+wait_len unstalled cycles.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    upc_d     = upc_q;
    illegal_d = illegal_q;
    start_d   = 1'b0;
    count_d   = count_q;
    take_nxt  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!hold) begin
          if (wait_len != 4'd0) begin
            wcnt_d  = wait_len;
            state_d = ST_WAIT;
          end else begin
            take_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!hold) begin
          if (wcnt_q > 4'd1) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            take_nxt = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (take_nxt) begin
      wcnt_d = 4'd0;
      if (nxt_addr == TRAP_ADDR) begin
        state_d   = ST_HALT;
        upc_d     = TRAP_ADDR;
        illegal_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        upc_d   = nxt_addr;
        if (addr_ctl == AC_FETCH) begin
          count_d = count_q + 16'd1;
          start_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset; reset overrides hold and any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wcnt_q    <= 4'd0;
      upc_q     <= FETCH_ADDR;
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      upc_q     <= upc_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      count_q   <= count_d;
    end
  end

  assign upc         = upc_q;
  assign instr_start = start_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed bench for micro_sequencer. Every driven step
// pushes the expected {state, upc, instr_start, illegal, instr_count} onto a
// queue; after the clock edge the entry is popped and compared.
module tb_micro_sequencer;

  localparam logic [1:0] RUN  = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam logic [1:0] SEQ   = 2'b00;
  localparam logic [1:0] DISP1 = 2'b01;
  localparam logic [1:0] DISP2 = 2'b10;
  localparam logic [1:0] FETCH = 2'b11;

  localparam int W = 25;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [1:0]  addr_ctl;
  logic [4:0]  dt1_addr;
  logic [4:0]  dt2_addr;
  logic        hold;
  logic [3:0]  wait_len;
  logic [4:0]  upc;
  logic        instr_start;
  logic        illegal;
  logic [15:0] instr_count;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .addr_ctl    (addr_ctl),
    .dt1_addr    (dt1_addr),
    .dt2_addr    (dt2_addr),
    .hold        (hold),
    .wait_len    (wait_len),
    .upc         (upc),
    .instr_start (instr_start),
    .illegal     (illegal),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total;
  int           bad;

  // Push the expectation, advance one edge, sample #1 later and compare.
  task automatic tick(input logic [4:0] e_upc, input logic e_start,
                      input logic e_ill, input logic [15:0] e_cnt,
                      input logic [1:0] e_st, input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    string        t;
    exp_q.push_back({e_st, e_upc, e_start, e_ill, e_cnt});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = {dbg_state, upc, instr_start, illegal, instr_count};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s: observed st=%0d upc=%0d start=%0b ill=%0b cnt=%0d expected st=%0d upc=%0d start=%0b ill=%0b cnt=%0d",
             t, obs_v[24:23], obs_v[22:18], obs_v[17], obs_v[16], obs_v[15:0],
             exp_v[24:23], exp_v[22:18], exp_v[17], exp_v[16], exp_v[15:0]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    addr_ctl = SEQ;
    dt1_addr = 5'd0;
    dt2_addr = 5'd0;
    hold     = 1'b0;
    wait_len = 4'd0;

    // Reset, then sequential stepping.
    tick(5'd0, 1'b0, 1'b0, 16'd0, RUN, "reset");
    rst = 1'b0;
    addr_ctl = SEQ;
    tick(5'd1, 1'b0, 1'b0, 16'd0, RUN, "seq1");
    tick(5'd2, 1'b0, 1'b0, 16'd0, RUN, "seq2");
    tick(5'd3, 1'b0, 1'b0, 16'd0, RUN, "seq3");

    // Dispatch from upc=1, then FETCH.
    rst = 1'b1;
    tick(5'd0, 1'b0, 1'b0, 16'd0, RUN, "reset2");
    rst = 1'b0;
    tick(5'd1, 1'b0, 1'b0, 16'd0, RUN, "seq_to1");
    addr_ctl = DISP1; dt1_addr = 5'b01100;
    tick(5'd12, 1'b0, 1'b0, 16'd0, RUN, "disp1");
    addr_ctl = FETCH;
    tick(5'd0, 1'b1, 1'b0, 16'd1, RUN, "fetch");
    addr_ctl = SEQ;
    tick(5'd1, 1'b0, 1'b0, 16'd1, RUN, "start_drop");
    addr_ctl = DISP2; dt2_addr = 5'd9;
    tick(5'd9, 1'b0, 1'b0, 16'd1, RUN, "disp2");

    // Hold in RUN freezes everything, including a pending FETCH.
    addr_ctl = FETCH; hold = 1'b1;
    tick(5'd9, 1'b0, 1'b0, 16'd1, RUN, "hold_run");
    hold = 1'b0;
    addr_ctl = DISP1; dt1_addr = 5'd16;
    tick(5'd16, 1'b0, 1'b0, 16'd1, RUN, "to16");

    // Multi-cycle microinstruction: 1+3 cycles at 16, then 17.
    addr_ctl = SEQ; wait_len = 4'd3;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "wait_load");
    wait_len = 4'd0;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "wait_2");
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "wait_1");
    tick(5'd17, 1'b0, 1'b0, 16'd1, RUN, "wait_exit");

    // Same with a 2-cycle hold inside WAIT: 6 cycles at 16.
    addr_ctl = DISP1; dt1_addr = 5'd16;
    tick(5'd16, 1'b0, 1'b0, 16'd1, RUN, "to16b");
    addr_ctl = SEQ; wait_len = 4'd3;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "hw_load");
    wait_len = 4'd0; hold = 1'b1;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "hw_hold1");
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "hw_hold2");
    hold = 1'b0;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "hw_dec1");
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "hw_dec2");
    tick(5'd17, 1'b0, 1'b0, 16'd1, RUN, "hw_exit");

    // Reset while in WAIT with wcnt=2.
    addr_ctl = DISP1; dt1_addr = 5'd16;
    tick(5'd16, 1'b0, 1'b0, 16'd1, RUN, "to16c");
    addr_ctl = SEQ; wait_len = 4'd3;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "rw_load");
    wait_len = 4'd0;
    tick(5'd16, 1'b0, 1'b0, 16'd1, WAIT, "rw_wcnt2");
    rst = 1'b1;
    tick(5'd0, 1'b0, 1'b0, 16'd0, RUN, "rst_in_wait");
    rst = 1'b0;
    tick(5'd1, 1'b0, 1'b0, 16'd0, RUN, "post_rst_wait");

    // Illegal dispatch to TRAP_ADDR, then HALT ignores inputs.
    addr_ctl = DISP1; dt1_addr = 5'b11111;
    tick(5'd31, 1'b0, 1'b1, 16'd0, HALT, "trap_disp1");
    addr_ctl = FETCH;
    tick(5'd31, 1'b0, 1'b1, 16'd0, HALT, "halt_fetch");
    addr_ctl = DISP2; dt2_addr = 5'd4;
    tick(5'd31, 1'b0, 1'b1, 16'd0, HALT, "halt_disp2");
    addr_ctl = SEQ; wait_len = 4'd5;
    tick(5'd31, 1'b0, 1'b1, 16'd0, HALT, "halt_wait");
    wait_len = 4'd0;

    // Reset out of HALT.
    rst = 1'b1;
    tick(5'd0, 1'b0, 1'b0, 16'd0, RUN, "rst_in_halt");
    rst = 1'b0;

    // 65536 FETCH transitions wrap instr_count.
    addr_ctl = FETCH;
    repeat (65534) @(posedge clk);
    #1;
    tick(5'd0, 1'b1, 1'b0, 16'hFFFF, RUN, "cnt_max");
    tick(5'd0, 1'b1, 1'b0, 16'd0, RUN, "cnt_wrap");

    // Sequential step from 30 traps.
    addr_ctl = DISP1; dt1_addr = 5'd30;
    tick(5'd30, 1'b0, 1'b0, 16'd0, RUN, "to30");
    addr_ctl = SEQ;
    tick(5'd31, 1'b0, 1'b1, 16'd0, HALT, "seq_trap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have parameter FETCH_ADDR, default 5'b00000, meaning the microcode address of instruction fetch.
REQ-002 The block SHALL have parameter TRAP_ADDR, default 5'b11111, meaning both the illegal-dispatch code and the halt address.
REQ-003 The block SHALL have port clk  input  1  the single system clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst  input  1  a synchronous, active-high reset.
REQ-005 The block SHALL have port addr_ctl  input  2  the next-address select of the current microinstruction: 00 SEQ (upc+1), 01 DISP1, 10 DISP2, 11 FETCH.
REQ-006 The block SHALL have port dt1_addr  input  5  the target from dispatch table 1 (opcode/funct decode).
REQ-007 The block SHALL have port dt2_addr  input  5  the target from dispatch table 2.
REQ-008 The block SHALL have port hold  input  1  an external stall (memory not ready) that freezes all sequencer state.
REQ-009 The block SHALL have port wait_len  input  4  the number of extra cycles the current microinstruction occupies (multi-cycle div/mul).
REQ-010 The block SHALL have port upc  output  5  the registered micro-PC that addresses the control store.
REQ-011 The block SHALL have port instr_start  output  1  a registered, one-cycle pulse marking the first cycle at FETCH_ADDR.
REQ-012 The block SHALL have port illegal  output  1  a sticky flag meaning a dispatch or sequential step reached TRAP_ADDR.
REQ-013 The block SHALL have port instr_count  output  16  a count of FETCH transitions taken, wrapping modulo 2^16.

Function
REQ-014 The block SHALL implement FSM states RUN, WAIT and HALT, plus a 4-bit wait counter wcnt.
REQ-015 In RUN with hold=1, upc, state, wcnt and instr_count SHALL hold, and instr_start SHALL be 0.
REQ-016 In RUN with hold=0 and wait_len!=0, the block SHALL load wcnt=wait_len, enter WAIT and leave upc unchanged.
REQ-017 In RUN with hold=0 and wait_len=0, the block SHALL apply the next-address select of REQ-018 to REQ-022 on the same edge.
REQ-018 SEQ SHALL set upc to (upc+1) mod 32.
REQ-019 DISP1 SHALL set upc to dt1_addr.
REQ-020 DISP2 SHALL set upc to dt2_addr.
REQ-021 FETCH SHALL set upc to FETCH_ADDR, increment instr_count and set instr_start=1 for the next cycle only.
REQ-022 Any next upc equal to TRAP_ADDR (illegal dispatch, or SEQ from 30) SHALL enter HALT, set upc=TRAP_ADDR and set illegal=1.
REQ-023 In WAIT with hold=1, all state SHALL freeze.
REQ-024 In WAIT with hold=0 and wcnt>1, the block SHALL decrement wcnt and hold upc.
REQ-025 In WAIT with hold=0 and wcnt=1, the block SHALL return to RUN and apply the next-address select on that edge, ignoring wait_len, so the microinstruction occupies exactly 1+wait_len unstalled cycles.
REQ-026 In HALT, upc SHALL remain TRAP_ADDR and illegal SHALL remain 1, with all inputs except rst ignored.
REQ-027 instr_start SHALL be 0 on every cycle except the one following a FETCH edge.
REQ-028 The block SHALL have latency of one clock from input sampling to upc update, with no combinational path from any input to any output.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set upc=FETCH_ADDR, state=RUN, wcnt=0, illegal=0, instr_start=0 and instr_count=0, regardless of hold or the current state.
REQ-030 Reset asserted mid-WAIT or in HALT SHALL abandon the wait or trap entirely, and the first post-reset cycle SHALL execute FETCH_ADDR.

Verification
REQ-031 The bench SHALL cover: reset, then addr_ctl=SEQ for 3 cycles -> upc=0,1,2,3; instr_start=0 throughout.
REQ-032 The bench SHALL cover: upc=1, addr_ctl=DISP1, dt1_addr=5'b01100 -> upc=12 next cycle; then FETCH -> upc=0, instr_start=1 for one cycle, instr_count=1.
REQ-033 The bench SHALL cover: upc=16, wait_len=3, addr_ctl=SEQ -> upc stays 16 for 4 cycles, then becomes 17; with hold=1 for 2 cycles inside WAIT -> upc stays 16 for 6 cycles.
REQ-034 The bench SHALL cover: addr_ctl=DISP1, dt1_addr=5'b11111 -> upc=31, illegal=1, state HALT; subsequent FETCH and DISP inputs leave upc=31.
REQ-035 The bench SHALL cover: rst pulsed while in WAIT (wcnt=2) and while in HALT -> upc=0, illegal=0, instr_count=0 on the next cycle.
REQ-036 The bench SHALL cover: 65536 FETCH transitions -> instr_count wraps to 0; SEQ from upc=30 -> upc=31, illegal=1.
